muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// FUNCT3 encodings, FSM state encoding and the CALC cycle count helper.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // Number of CALC cycles for a given width and radix-2 steps per cycle.
  function automatic int calc_cycles(input int xlen, input int bits_per_cycle);
    return xlen / bits_per_cycle;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step on the shared 2*XLEN accumulator.
//   multiply: acc = {partial_hi, multiplier_remaining}; add operand to the
//             high half when the current multiplier bit is set, shift right.
//   divide:   acc = {remainder, dividend/quotient}; shift left one bit,
//             subtract the divisor when it fits, shift the quotient bit in.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_trial;
  logic [XLEN-1:0] rem_diff;

  // Single add-shift or compare-subtract-shift step
  always_comb begin
    acc_out   = '0;
    add_sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    rem_trial = acc_in[2*XLEN-1:XLEN-1];
    rem_diff  = rem_trial[XLEN-1:0] - operand;
    if (is_div) begin
      if (rem_trial >= {1'b0, operand}) begin
        acc_out = {rem_diff, acc_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = {rem_trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_out = {add_sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Operands are latched as magnitudes at launch, BITS_PER_CYCLE radix-2
// steps run per CALC cycle, and sign correction plus result selection
// happen on the FINAL edge.
// Optional build macro: MULDIV_EARLY_OUT_EN -- trivial cases (divide by
// zero, signed overflow, multiply by zero, |dividend| < |divisor|) skip
// CALC and go IDLE -> FINAL. Results are identical either way.
//
// Handshake: START is held high while the instruction sits in EX. BUSY
// stalls the pipeline while (START & ~DONE) or the FSM is not IDLE. DONE
// pulses one cycle with RESULT valid and BUSY low; START seen while DONE=1
// is ignored so the same instruction is never launched twice. KILL aborts
// at any edge and beats both START and the FINAL transition.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            KILL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output state_t          dbg_state
);

  localparam int N = calc_cycles(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*XLEN-1:0]  acc, acc_next, acc_init;
  logic [XLEN-1:0]    operand_q, op1_q;
  logic [2:0]         funct3_q;
  logic               neg_q, rem_neg_q, div_zero_q;

  logic               launch, is_div_in, a_signed, b_signed, a_neg, b_neg;
  logic               div_zero_in, early;
  logic [XLEN-1:0]    a_mag, b_mag;

  logic [2*XLEN-1:0]  prod_s;
  logic [XLEN-1:0]    quo_s, rem_s, final_res;

  assign dbg_state = state;
  assign launch    = (state == ST_IDLE) & START & ~DONE & ~KILL;
  assign BUSY      = ~RESET & ((START & ~DONE) | (state != ST_IDLE));

  // Launch decode: signedness per FUNCT3, magnitudes, early-out detection
  always_comb begin
    is_div_in   = FUNCT3[2];
    a_signed    = (FUNCT3 == F3_MULH) | (FUNCT3 == F3_MULHSU) |
                  (FUNCT3 == F3_DIV)  | (FUNCT3 == F3_REM);
    b_signed    = (FUNCT3 == F3_MULH) | (FUNCT3 == F3_DIV) | (FUNCT3 == F3_REM);
    a_neg       = a_signed & OPERAND1[XLEN-1];
    b_neg       = b_signed & OPERAND2[XLEN-1];
    a_mag       = a_neg ? -OPERAND1 : OPERAND1;
    b_mag       = b_neg ? -OPERAND2 : OPERAND2;
    div_zero_in = is_div_in & (OPERAND2 == '0);
`ifdef MULDIV_EARLY_OUT_EN
    if (is_div_in) begin
      early = div_zero_in | (a_mag < b_mag) |
              (a_signed & (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) & (OPERAND2 == '1));
    end else begin
      early = (OPERAND1 == '0) | (OPERAND2 == '0);
    end
`else
    early = 1'b0;
`endif
    // Early-out accumulators hold the finished unsigned answer; overflow
    // already has it as {0, |dividend|} because |divisor| is 1.
    if (!is_div_in) begin
      acc_init = early ? '0 : {{XLEN{1'b0}}, b_mag};
    end else if (early && (a_mag < b_mag)) begin
      acc_init = {a_mag, {XLEN{1'b0}}};
    end else begin
      acc_init = {{XLEN{1'b0}}, a_mag};
    end
  end

  // Chain of BITS_PER_CYCLE radix-2 steps evaluated each CALC cycle
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [2*XLEN-1:0] stage_in, stage_out;
    if (i == 0) begin : g_first
      assign stage_in = acc;
    end else begin : g_next
      assign stage_in = g_step[i-1].stage_out;
    end
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (funct3_q[2]),
      .acc_in  (stage_in),
      .operand (operand_q),
      .acc_out (stage_out)
    );
  end
  assign acc_next = g_step[BITS_PER_CYCLE-1].stage_out;

  // Sign correction and result select applied on the FINAL edge
  always_comb begin
    prod_s    = neg_q ? -acc : acc;
    quo_s     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s     = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    final_res = '0;
    case (funct3_q)
      F3_MUL:                         final_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   final_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                final_res = div_zero_q ? '1 : quo_s;
      default:                        final_res = div_zero_q ? op1_q : rem_s;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: KILL wins over everything
  always_comb begin
    state_nxt = state;
    if (KILL) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (START && !DONE) state_nxt = early ? ST_FINAL : ST_CALC;
        ST_CALC:  if (cnt == CNT_LAST) state_nxt = ST_FINAL;
        ST_FINAL: state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, result and DONE pulse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      acc        <= '0;
      operand_q  <= '0;
      op1_q      <= '0;
      funct3_q   <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      RESULT     <= '0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (launch) begin
        cnt        <= '0;
        acc        <= acc_init;
        operand_q  <= is_div_in ? b_mag : a_mag;
        op1_q      <= OPERAND1;
        funct3_q   <= FUNCT3;
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        div_zero_q <= div_zero_in;
      end else if (state == ST_CALC && !KILL) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (state == ST_FINAL && !KILL) begin
        RESULT <= final_res;
        DONE   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: three instances (1, 4 and 2 bits per
// cycle) run a shared vector table, then hand sequences cover KILL,
// START/KILL priority, asynchronous reset and the per-radix latencies.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int NV = 22;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic        kill;
  logic        busy_v [3];
  logic        done_v [3];
  logic [31:0] result_v [3];
  state_t      dbg_v [3];

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs [NV];
  int          n_of [3] = '{32, 8, 16};

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .CLK(clk), .RESET(rst), .START(start_v[0]), .FUNCT3(funct3), .OPERAND1(op1),
    .OPERAND2(op2), .KILL(kill), .BUSY(busy_v[0]), .DONE(done_v[0]),
    .RESULT(result_v[0]), .dbg_state(dbg_v[0]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .CLK(clk), .RESET(rst), .START(start_v[1]), .FUNCT3(funct3), .OPERAND1(op1),
    .OPERAND2(op2), .KILL(kill), .BUSY(busy_v[1]), .DONE(done_v[1]),
    .RESULT(result_v[1]), .dbg_state(dbg_v[1]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut2 (
    .CLK(clk), .RESET(rst), .START(start_v[2]), .FUNCT3(funct3), .OPERAND1(op1),
    .OPERAND2(op2), .KILL(kill), .BUSY(busy_v[2]), .DONE(done_v[2]),
    .RESULT(result_v[2]), .dbg_state(dbg_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op on instance w, scramble inputs after launch, and check
  // result (from exp_q), DONE latency, BUSY cycle count and the DONE cycle.
  task automatic run_op(input int w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input string tag);
    logic [31:0] res;
    logic [31:0] exp_res;
    logic        busy_at_done;
    int          lat, bcnt;
    bit          got;
    exp_res = exp_q.pop_front();
    @(negedge clk);
    funct3 = f3; op1 = a; op2 = b; start_v[w] = 1'b1;
    got = 1'b0; lat = 0; bcnt = 0; res = '0; busy_at_done = 1'b1;
    while (!got && lat < 200) begin
      #1;
      if (busy_v[w]) bcnt++;
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        op1 = $urandom(); op2 = $urandom(); funct3 = 3'($urandom_range(0, 7));
      end
      if (done_v[w]) begin
        got = 1'b1; res = result_v[w]; busy_at_done = busy_v[w];
      end
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, bcnt, exp_lat);
    check({tag, " busy in done"}, 32'(busy_at_done), 32'd0);
    // START still high across the DONE edge must not relaunch
    @(negedge clk);
    start_v[w] = 1'b0;
    #1;
    check({tag, " no relaunch done"}, 32'(done_v[w]), 32'd0);
    check({tag, " no relaunch busy"}, 32'(busy_v[w]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
    for (int w = 0; w < 3; w++) start_v[w] = 1'b0;

    vecs = '{
      '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
      '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
      '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
      '{F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
      '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0},
      '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0},
      '{F3_DIVU,   32'd7,        32'd2,        32'd3,        1'b0},
      '{F3_REMU,   32'd7,        32'd2,        32'd1,        1'b0},
      '{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1},
      '{F3_REMU,   32'd5,        32'd0,        32'd5,        1'b1},
      '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
      '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},
      '{F3_MULH,   32'd0,        32'h00001234, 32'h00000000, 1'b1},
      '{F3_DIVU,   32'd3,        32'd10,       32'd0,        1'b1},
      '{F3_REM,    32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, 1'b1},
      '{F3_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1},
      '{F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1},
      '{F3_MULHSU, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0},
      '{F3_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0},
      '{F3_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        1'b0},
      '{F3_MULHU,  32'h80000000, 32'd4,        32'd2,        1'b0}
    };

    // Reset state
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("reset busy d%0d", w), 32'(busy_v[w]), 32'd0);
      check($sformatf("reset done d%0d", w), 32'(done_v[w]), 32'd0);
      check($sformatf("reset result d%0d", w), result_v[w], 32'd0);
      check($sformatf("reset state d%0d", w), 32'(dbg_v[w]), 32'(ST_IDLE));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Vector table on all three radices
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < NV; i++) begin
        exp_q.push_back(vecs[i].exp);
        run_op(w, vecs[i].f3, vecs[i].a, vecs[i].b,
               (EARLY && vecs[i].early) ? 2 : n_of[w] + 2, $sformatf("d%0d v%0d", w, i));
      end
    end

    // Radix-specific latencies
    exp_q.push_back(32'd14);
    run_op(1, F3_DIVU, 32'd100, 32'd7, 10, "bpc4 divu 100/7");
    exp_q.push_back(32'd2);
    run_op(2, F3_REMU, 32'd100, 32'd7, 18, "bpc2 remu 100/7");

    // KILL beats the FINAL transition (bpc4: FINAL is cycle 10)
    @(negedge clk);
    funct3 = F3_DIVU; op1 = 32'd100; op2 = 32'd7; start_v[1] = 1'b1;
    repeat (9) @(negedge clk);
    check("kill final state", 32'(dbg_v[1]), 32'(ST_FINAL));
    kill = 1'b1; start_v[1] = 1'b0;
    @(posedge clk); #1;
    check("kill final done", 32'(done_v[1]), 32'd0);
    check("kill final busy", 32'(busy_v[1]), 32'd0);
    check("kill final result kept", result_v[1], 32'd14);
    @(negedge clk);
    kill = 1'b0;

    // KILL in cycle 10 of a DIV on the radix-2 instance
    funct3 = F3_DIV; op1 = 32'd100; op2 = 32'd7; start_v[0] = 1'b1;
    repeat (9) @(negedge clk);
    check("kill calc busy before", 32'(busy_v[0]), 32'd1);
    kill = 1'b1; start_v[0] = 1'b0;
    @(posedge clk); #1;
    check("kill calc busy after", 32'(busy_v[0]), 32'd0);
    check("kill calc state", 32'(dbg_v[0]), 32'(ST_IDLE));
    check("kill calc result kept", result_v[0], vecs[NV-1].exp);
    @(negedge clk);
    kill = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("kill calc no done %0d", c), 32'(done_v[0]), 32'd0);
    end
    exp_q.push_back(32'd0);
    run_op(0, F3_MULHU, 32'd3, 32'd5, 34, "mulhu after kill");

    // KILL together with START in IDLE: no launch
    @(negedge clk);
    funct3 = F3_MUL; op1 = 32'd9; op2 = 32'd9; start_v[0] = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    check("kill vs start state", 32'(dbg_v[0]), 32'(ST_IDLE));
    @(negedge clk);
    start_v[0] = 1'b0; kill = 1'b0;

    // Asynchronous reset in cycle 20 of a DIV
    exp_q.push_back(32'hFFFFFFEB);
    run_op(0, F3_MUL, 32'd7, 32'hFFFFFFFD, 34, "mul before reset");
    @(negedge clk);
    funct3 = F3_DIV; op1 = 32'd100; op2 = 32'd7; start_v[0] = 1'b1;
    repeat (19) @(negedge clk);
    check("reset mid busy before", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("async reset busy d%0d", w), 32'(busy_v[w]), 32'd0);
      check($sformatf("async reset done d%0d", w), 32'(done_v[w]), 32'd0);
      check($sformatf("async reset result d%0d", w), result_v[w], 32'd0);
    end
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'd3);
    run_op(0, F3_DIVU, 32'd7, 32'd2, 34, "divu after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
